ser_frame_tx: RTL and testbench

SER_FRAME_TX -- requirements
Module: ser_frame_tx

---
 rtl/ser_frame_pkg.sv | 26 ++
 rtl/ser_frame_tx_bit_tick_gen.sv | 56 +++++
 rtl/ser_frame_tx.sv | 148 ++++++++++++++
 tb/tb_ser_frame_tx.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ser_frame_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ser_frame_pkg
//  Description : Shared state encoding and line-level constant for the
//                ser_frame_tx serial frame transmitter.
//                The PARITY state exists only when SER_FRAME_TX_PARITY_EN
//                is defined.
//  Revision    : 1.0  initial release
// ============================================================================
package ser_frame_pkg;

    // Level the serial line rests at between frames (also the stop level).
    localparam logic c_IDLE_LEVEL = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef SER_FRAME_TX_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4
    } state_e;

endpackage : ser_frame_pkg
`default_nettype wire

// File: rtl/ser_frame_tx_bit_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module      : bit_tick_gen
//  Description : Bit-period counter for ser_frame_tx. Counts 0..CLKS_PER_BIT-1
//                and wraps; tick is high on the last cycle of each period.
//                clear holds the count at zero so a period starts cleanly.
//                With CLKS_PER_BIT=1 every cycle is a full bit period.
//  Revision    : 1.0  initial release
// ============================================================================
module bit_tick_gen #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    generate
        if (CLKS_PER_BIT > 1) begin : g_cnt
            localparam int CW = $clog2(CLKS_PER_BIT);
            localparam logic [CW-1:0] c_LAST = CW'(CLKS_PER_BIT - 1);

            logic [CW-1:0] r_cnt_q;
            logic [CW-1:0] w_cnt_d;

            // Next count: held at zero while cleared, wraps after the last cycle.
            always_comb begin
                w_cnt_d = r_cnt_q;
                if (clear || (r_cnt_q == c_LAST)) begin
                    w_cnt_d = '0;
                end else begin
                    w_cnt_d = r_cnt_q + CW'(1);
                end
            end

            // Count register, asynchronously cleared by the active-low reset.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_cnt_q <= '0;
                end else begin
                    r_cnt_q <= w_cnt_d;
                end
            end

            assign tick = (r_cnt_q == c_LAST);
        end else begin : g_no_cnt
            // One clock per bit: no state needed, every cycle ends a period.
            logic w_unused_inputs;
            assign w_unused_inputs = clk ^ rst ^ clear;
            assign tick            = 1'b1;
        end
    endgenerate

endmodule : bit_tick_gen
`default_nettype wire

// File: rtl/ser_frame_tx.sv
`default_nettype none
// ============================================================================
//  Module      : ser_frame_tx
//  Description : Parallel-to-serial frame transmitter. Frame is a low start
//                bit, DATA_W payload bits LSB first, an optional even-parity
//                bit, and a high stop bit; each bit lasts CLKS_PER_BIT clocks.
//                Build option: define SER_FRAME_TX_PARITY_EN to insert the
//                even-parity bit between payload and stop bit.
//  Revision    : 1.0  initial release
// ============================================================================
module ser_frame_tx
    import ser_frame_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data,
    input  logic              valid,
    output logic              ready,
    output logic              tx,
    output logic              busy
);

    localparam int BW = $clog2(DATA_W + 1);
    localparam logic [BW-1:0] c_LAST_BIT = BW'(DATA_W - 1);

    state_e            r_state_q,   w_state_d;
    logic [DATA_W-1:0] r_shift_q,   w_shift_d;
    logic [BW-1:0]     r_bit_cnt_q, w_bit_cnt_d;
    logic              r_tx_q,      w_tx_d;
`ifdef SER_FRAME_TX_PARITY_EN
    logic              r_parity_q,  w_parity_d;
`endif

    logic w_tick;
    logic w_clear;
    logic w_accept;

    assign ready    = (r_state_q == ST_IDLE);
    assign busy     = ~ready;
    assign tx       = r_tx_q;
    assign w_accept = valid & ready;

    // Bit-period timer held in reset while idle so START begins a fresh period.
    assign w_clear = (r_state_q == ST_IDLE);

    bit_tick_gen #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_bit_tick_gen (
        .clk   (clk),
        .rst   (rst),
        .clear (w_clear),
        .tick  (w_tick)
    );

    // Next-state, shift register, bit counter and next line level.
    always_comb begin
        w_state_d   = r_state_q;
        w_shift_d   = r_shift_q;
        w_bit_cnt_d = r_bit_cnt_q;
`ifdef SER_FRAME_TX_PARITY_EN
        w_parity_d  = r_parity_q;
`endif
        case (r_state_q)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_d  = ST_START;
                    w_shift_d  = data;
`ifdef SER_FRAME_TX_PARITY_EN
                    w_parity_d = ^data;
`endif
                end
            end
            ST_START: begin
                if (w_tick) begin
                    w_state_d   = ST_DATA;
                    w_bit_cnt_d = '0;
                end
            end
            ST_DATA: begin
                if (w_tick) begin
                    w_shift_d   = r_shift_q >> 1;
                    w_bit_cnt_d = r_bit_cnt_q + BW'(1);
                    if (r_bit_cnt_q == c_LAST_BIT) begin
`ifdef SER_FRAME_TX_PARITY_EN
                        w_state_d = ST_PARITY;
`else
                        w_state_d = ST_STOP;
`endif
                    end
                end
            end
`ifdef SER_FRAME_TX_PARITY_EN
            ST_PARITY: begin
                if (w_tick) begin
                    w_state_d = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (w_tick) begin
                    w_state_d = ST_IDLE;
                end
            end
            default: begin
                w_state_d = ST_IDLE;
            end
        endcase

        // The line is registered, so it is derived from the state being entered.
        w_tx_d = c_IDLE_LEVEL;
        case (w_state_d)
            ST_IDLE:   w_tx_d = c_IDLE_LEVEL;
            ST_START:  w_tx_d = ~c_IDLE_LEVEL;
            ST_DATA:   w_tx_d = w_shift_d[0];
`ifdef SER_FRAME_TX_PARITY_EN
            ST_PARITY: w_tx_d = w_parity_d;
`endif
            ST_STOP:   w_tx_d = c_IDLE_LEVEL;
            default:   w_tx_d = c_IDLE_LEVEL;
        endcase
    end

    // State and datapath registers; reset aborts any frame immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state_q   <= ST_IDLE;
            r_shift_q   <= '0;
            r_bit_cnt_q <= '0;
            r_tx_q      <= c_IDLE_LEVEL;
`ifdef SER_FRAME_TX_PARITY_EN
            r_parity_q  <= 1'b0;
`endif
        end else begin
            r_state_q   <= w_state_d;
            r_shift_q   <= w_shift_d;
            r_bit_cnt_q <= w_bit_cnt_d;
            r_tx_q      <= w_tx_d;
`ifdef SER_FRAME_TX_PARITY_EN
            r_parity_q  <= w_parity_d;
`endif
        end
    end

endmodule : ser_frame_tx
`default_nettype wire

// File: tb/tb_ser_frame_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ser_frame_tx
//  Description : Self-checking bench for ser_frame_tx. A frame model builds
//                the expected bit list from the payload; per-cycle line
//                levels follow from dividing the cycle index by CLKS_PER_BIT.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ser_frame_tx;

    localparam int DW  = 8;
    localparam int CPB = 4;
`ifdef SER_FRAME_TX_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif
    localparam int NB  = PAR ? DW + 3 : DW + 2;
    localparam int LEN = NB * CPB;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] data,  data1;
    logic          valid, valid1;
    logic          ready, ready1;
    logic          tx,    tx1;
    logic          busy,  busy1;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    ser_frame_tx #(.DATA_W(DW), .CLKS_PER_BIT(CPB)) dut (
        .clk(clk), .rst(rst), .data(data), .valid(valid),
        .ready(ready), .tx(tx), .busy(busy)
    );

    ser_frame_tx #(.DATA_W(DW), .CLKS_PER_BIT(1)) dut1 (
        .clk(clk), .rst(rst), .data(data1), .valid(valid1),
        .ready(ready1), .tx(tx1), .busy(busy1)
    );

    // Frame model: bit idx of the frame carrying payload d.
    function automatic logic model_bit(input logic [DW-1:0] d, input int idx);
        logic [15:0] frame;
        frame    = '1;
        frame[0] = 1'b0;
        for (int i = 0; i < DW; i++) frame[1 + i] = d[i];
        if (PAR) frame[DW + 1] = ^d;
        return frame[idx];
    endfunction

    task automatic test_reset();
        rst = 1'b1; valid = 1'b0; valid1 = 1'b0; data = '0; data1 = '0;
        #1 rst = 1'b0;
        #1;
        total_cnt++;
        if (tx !== 1'b1 || ready !== 1'b1 || busy !== 1'b0) begin
            $display("FAIL reset_state: tx=%b ready=%b busy=%b, expected 1 1 0", tx, ready, busy);
        end else pass_cnt++;
        total_cnt++;
        if (tx1 !== 1'b1 || ready1 !== 1'b1 || busy1 !== 1'b0) begin
            $display("FAIL reset_state_cpb1: tx=%b ready=%b busy=%b, expected 1 1 0", tx1, ready1, busy1);
        end else pass_cnt++;
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Offer one payload and check every cycle of its frame plus the return to idle.
    task automatic test_frame(input logic [DW-1:0] d, input string name);
        logic exp;
        @(negedge clk);
        total_cnt++;
        if (ready !== 1'b1 || tx !== 1'b1) begin
            $display("FAIL %s_idle: ready=%b tx=%b, expected 1 1", name, ready, tx);
        end else pass_cnt++;
        data = d; valid = 1'b1;
        for (int k = 0; k < LEN; k++) begin
            @(negedge clk);
            exp = model_bit(d, k / CPB);
            total_cnt++;
            if (tx !== exp || ready !== 1'b0 || busy !== 1'b1) begin
                $display("FAIL %s cycle %0d: tx=%b ready=%b busy=%b, expected tx=%b ready=0 busy=1",
                         name, k, tx, ready, busy, exp);
            end else pass_cnt++;
            if (k == 0) begin
                valid = 1'b0;
                data  = DW'($urandom);
            end
        end
        @(negedge clk);
        total_cnt++;
        if (ready !== 1'b1 || tx !== 1'b1 || busy !== 1'b0) begin
            $display("FAIL %s_end: ready=%b tx=%b busy=%b after %0d cycles, expected 1 1 0",
                     name, ready, tx, busy, LEN);
        end else pass_cnt++;
    endtask

    // Two payloads streamed; d2 is offered at cycle offer_at of the first frame.
    task automatic run_pair(input logic [DW-1:0] d1, input logic [DW-1:0] d2,
                            input int offer_at, input string name);
        logic exp;
        @(negedge clk);
        data = d1; valid = 1'b1;
        for (int k = 0; k < LEN; k++) begin
            @(negedge clk);
            exp = model_bit(d1, k / CPB);
            total_cnt++;
            if (tx !== exp || ready !== 1'b0) begin
                $display("FAIL %s first cycle %0d: tx=%b ready=%b, expected tx=%b ready=0",
                         name, k, tx, ready, exp);
            end else pass_cnt++;
            if (k == 0) begin
                valid = (offer_at == 0);
                data  = (offer_at == 0) ? d2 : DW'($urandom);
            end else if (k == offer_at) begin
                valid = 1'b1;
                data  = d2;
            end
        end
        @(negedge clk);
        total_cnt++;
        if (tx !== 1'b1 || ready !== 1'b1 || busy !== 1'b0) begin
            $display("FAIL %s gap: tx=%b ready=%b busy=%b, expected 1 1 0", name, tx, ready, busy);
        end else pass_cnt++;
        for (int k = 0; k < LEN; k++) begin
            @(negedge clk);
            exp = model_bit(d2, k / CPB);
            total_cnt++;
            if (tx !== exp || ready !== 1'b0) begin
                $display("FAIL %s second cycle %0d: tx=%b ready=%b, expected tx=%b ready=0",
                         name, k, tx, ready, exp);
            end else pass_cnt++;
            if (k == 0) begin
                valid = 1'b0;
                data  = DW'($urandom);
            end
        end
        @(negedge clk);
        total_cnt++;
        if (ready !== 1'b1 || tx !== 1'b1) begin
            $display("FAIL %s end: ready=%b tx=%b, expected 1 1", name, ready, tx);
        end else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        run_pair(8'h3C, 8'hC3, 0, "back_to_back");
    endtask

    task automatic test_busy_offer();
        run_pair(DW'($urandom), DW'($urandom), LEN / 2, "busy_offer");
    endtask

    task automatic test_reset_mid();
        logic [DW-1:0] d;
        logic          bad;
        d = DW'($urandom);
        @(negedge clk);
        data = d; valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        repeat (3 * CPB + 1) @(negedge clk);
        #1 rst = 1'b0;
        #1;
        total_cnt++;
        if (tx !== 1'b1 || ready !== 1'b1 || busy !== 1'b0) begin
            $display("FAIL reset_mid: tx=%b ready=%b busy=%b, expected 1 1 0", tx, ready, busy);
        end else pass_cnt++;
        @(negedge clk);
        rst = 1'b1;
        bad = 1'b0;
        for (int k = 0; k < 2 * LEN; k++) begin
            @(negedge clk);
            if (tx !== 1'b1 || ready !== 1'b1) bad = 1'b1;
        end
        total_cnt++;
        if (bad) begin
            $display("FAIL reset_residual: line left idle after reset release, bad=%b expected 0", bad);
        end else pass_cnt++;
    endtask

    task automatic test_release_accept();
        logic [DW-1:0] d;
        logic          exp;
        d = DW'($urandom);
        @(negedge clk);
        rst = 1'b0; data = d; valid = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < LEN; k++) begin
            @(negedge clk);
            exp = model_bit(d, k / CPB);
            total_cnt++;
            if (tx !== exp || ready !== 1'b0) begin
                $display("FAIL release_accept cycle %0d: tx=%b ready=%b, expected tx=%b ready=0",
                         k, tx, ready, exp);
            end else pass_cnt++;
            if (k == 0) valid = 1'b0;
        end
        @(negedge clk);
        total_cnt++;
        if (ready !== 1'b1) begin
            $display("FAIL release_accept_end: ready=%b, expected 1", ready);
        end else pass_cnt++;
    endtask

    task automatic test_cpb1();
        logic exp;
        @(negedge clk);
        data1 = 8'hFF; valid1 = 1'b1;
        for (int k = 0; k < NB; k++) begin
            @(negedge clk);
            exp = model_bit(8'hFF, k);
            total_cnt++;
            if (tx1 !== exp || ready1 !== 1'b0) begin
                $display("FAIL cpb1 cycle %0d: tx=%b ready=%b, expected tx=%b ready=0", k, tx1, ready1, exp);
            end else pass_cnt++;
            if (k == 0) valid1 = 1'b0;
        end
        @(negedge clk);
        total_cnt++;
        if (ready1 !== 1'b1 || tx1 !== 1'b1) begin
            $display("FAIL cpb1_end: ready=%b tx=%b, expected 1 1", ready1, tx1);
        end else pass_cnt++;
    endtask

    task automatic test_random();
        for (int n = 0; n < 4; n++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            test_frame(DW'($urandom), "random");
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_frame(8'hA5, "frame_a5");
        test_frame(8'h01, "frame_01");
        test_back_to_back();
        test_busy_offer();
        test_reset_mid();
        test_release_accept();
        test_cpb1();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule : tb_ser_frame_tx
`default_nettype wire
